// File: rtl/gemm_pkg.sv
// ---------------------------------------------------------------------------
// gemm_pkg
// Shared constants and types for the GEMM result path. The result packer and
// the result unpacker both agree on these widths: 16-bit results packed
// sixteen to a 256-bit BRAM line, addressed by a 13-bit entry pointer whose
// low four bits select the lane and whose high nine bits select the line.
// ---------------------------------------------------------------------------
package gemm_pkg;

    localparam int RESULT_W      = 16;
    localparam int RESULT_LINE_W = 256;
    localparam int RESULT_PTR_W  = 13;
    localparam int RESULT_LANES  = RESULT_LINE_W / RESULT_W;
    localparam int RESULT_LANE_W = $clog2(RESULT_LANES);
    localparam int RESULT_ADDR_W = RESULT_PTR_W - RESULT_LANE_W;

    // Lane k of a line sits at bits [16k+15:16k].
    typedef logic [RESULT_LANES-1:0][RESULT_W-1:0] result_line_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        STREAM   = 2'd3
    } unpack_state_t;

endpackage

// File: rtl/result_bram_unpacker.sv
// ---------------------------------------------------------------------------
// result_bram_unpacker
// Drains the packed result BRAM. Reads one 256-bit line at a time through the
// BRAM read port (1-cycle read latency), then streams its lanes out one result
// per cycle on a valid/ready interface. Owns the entry read pointer that the
// packer uses to compute occupancy.
//
// Ports
//   i_clk           sole clock
//   i_reset         asynchronous, active-high reset
//   i_wr_ptr        packer entry write pointer (entries below it are committed)
//   i_flush         single-cycle pulse, discard all unread entries
//   o_bram_rd_en    BRAM read enable
//   o_bram_rd_addr  BRAM line address (line part of the read pointer)
//   i_bram_rd_data  BRAM read data, valid one cycle after o_bram_rd_en
//   o_valid         o_data holds an unread result
//   o_data          current result
//   i_ready         consumer accepts o_data when o_valid && i_ready
//   o_rd_ptr        entry read pointer, fed back to the packer
//   o_used          unread entries, {1'b0, i_wr_ptr - o_rd_ptr}
//   o_empty         i_wr_ptr == o_rd_ptr
//   o_state         current FSM state (debug visibility)
//
// Handshake: a result transfers on every rising edge where o_valid and
// i_ready are both high; once o_valid is up, o_valid and o_data hold until
// that transfer, except when a flush or reset discards the result.
// ---------------------------------------------------------------------------
module result_bram_unpacker
    import gemm_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [RESULT_PTR_W-1:0]  i_wr_ptr,
    input  logic                     i_flush,
    output logic                     o_bram_rd_en,
    output logic [RESULT_ADDR_W-1:0] o_bram_rd_addr,
    input  logic [RESULT_LINE_W-1:0] i_bram_rd_data,
    output logic                     o_valid,
    output logic [RESULT_W-1:0]      o_data,
    input  logic                     i_ready,
    output logic [RESULT_PTR_W-1:0]  o_rd_ptr,
    output logic [RESULT_PTR_W:0]    o_used,
    output logic                     o_empty,
    output unpack_state_t            o_state
);

    unpack_state_t             state_q, state_d;
    logic [RESULT_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [RESULT_PTR_W-1:0]   limit_q, limit_d;
    result_line_t              line_q, line_d;

    logic [RESULT_PTR_W-1:0]   ptr_inc;
    logic [RESULT_LANE_W-1:0]  lane_sel;
    logic                      empty;

    assign ptr_inc  = rd_ptr_q + RESULT_PTR_W'(1);
    assign lane_sel = rd_ptr_q[RESULT_LANE_W-1:0];
    assign empty    = (i_wr_ptr == rd_ptr_q);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= IDLE;
            rd_ptr_q <= '0;
            limit_q  <= '0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            limit_q  <= limit_d;
            line_q   <= line_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        limit_d  = limit_q;
        line_d   = line_q;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                // Everything below this snapshot has already been committed to
                // the BRAM, so the line being read holds valid data for it.
                limit_d = i_wr_ptr;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                line_d  = i_bram_rd_data;
                state_d = STREAM;
            end
            STREAM: begin
                if (i_ready) begin
                    rd_ptr_d = ptr_inc;
                    // Leaving the line, or reaching entries the captured line
                    // may not contain yet: go back and re-read.
                    if ((ptr_inc[RESULT_LANE_W-1:0] == '0) || (ptr_inc == limit_q)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush wins over everything, including a same-cycle accept.
        if (i_flush) begin
            rd_ptr_d = i_wr_ptr;
            state_d  = IDLE;
        end
    end

    assign o_bram_rd_en   = (state_q == RD_ISSUE);
    assign o_bram_rd_addr = rd_ptr_q[RESULT_PTR_W-1:RESULT_LANE_W];
    assign o_valid        = (state_q == STREAM);
    assign o_data         = line_q[lane_sel];
    assign o_rd_ptr       = rd_ptr_q;
    assign o_used         = {1'b0, i_wr_ptr - rd_ptr_q};
    assign o_empty        = empty;
    assign o_state        = state_q;

endmodule

// File: tb/tb_result_bram_unpacker.sv
// ---------------------------------------------------------------------------
// tb_result_bram_unpacker
// Directed bench for result_bram_unpacker with a behavioural 1-cycle BRAM.
// ---------------------------------------------------------------------------
module tb_result_bram_unpacker;
    import gemm_pkg::*;

    // ---------------- clock / reset ----------------
    logic                     i_clk;
    logic                     i_reset;
    logic [RESULT_PTR_W-1:0]  i_wr_ptr;
    logic                     i_flush;
    logic                     o_bram_rd_en;
    logic [RESULT_ADDR_W-1:0] o_bram_rd_addr;
    logic [RESULT_LINE_W-1:0] i_bram_rd_data;
    logic                     o_valid;
    logic [RESULT_W-1:0]      o_data;
    logic                     i_ready;
    logic [RESULT_PTR_W-1:0]  o_rd_ptr;
    logic [RESULT_PTR_W:0]    o_used;
    logic                     o_empty;
    unpack_state_t            o_state;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    result_bram_unpacker dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_wr_ptr       (i_wr_ptr),
        .i_flush        (i_flush),
        .o_bram_rd_en   (o_bram_rd_en),
        .o_bram_rd_addr (o_bram_rd_addr),
        .i_bram_rd_data (i_bram_rd_data),
        .o_valid        (o_valid),
        .o_data         (o_data),
        .i_ready        (i_ready),
        .o_rd_ptr       (o_rd_ptr),
        .o_used         (o_used),
        .o_empty        (o_empty),
        .o_state        (o_state)
    );

    // ---------------- BRAM model ----------------
    logic [RESULT_LINE_W-1:0] mem [512];
    int                       rd_cnt = 0;
    logic [RESULT_ADDR_W-1:0] addr_log [256];

    always @(posedge i_clk) begin
        if (o_bram_rd_en) begin
            i_bram_rd_data          <= mem[o_bram_rd_addr];
            addr_log[rd_cnt[7:0]]   <= o_bram_rd_addr;
            rd_cnt                  <= rd_cnt + 1;
        end
    end

    // ---------------- scoreboard ----------------
    int              checks   = 0;
    int              failures = 0;
    logic [15:0]     exp_q [$];
    int              acc_cyc [$];
    int              acc_used [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic write_entry(input logic [RESULT_PTR_W-1:0] ptr, input logic [15:0] val);
        mem[ptr[RESULT_PTR_W-1:RESULT_LANE_W]][ptr[RESULT_LANE_W-1:0]*16 +: 16] = val;
    endtask

    // Consume n results, comparing each to exp_q; optional random backpressure.
    task automatic drain(input int n, input bit rand_ready, input string tag);
        int          got = 0;
        int          cyc = 0;
        bit          stalled = 0;
        logic [15:0] held = '0;
        acc_cyc.delete();
        acc_used.delete();
        while (got < n && cyc < 2000) begin
            tick();
            cyc++;
            if (stalled) begin
                check($sformatf("%s_hold", tag), {o_valid, o_data}, {1'b1, held});
            end
            i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_valid && i_ready) begin
                check($sformatf("%s_data%0d", tag, got), o_data, exp_q.pop_front());
                acc_cyc.push_back(cyc);
                acc_used.push_back(int'(o_used));
                got++;
                stalled = 0;
            end else if (o_valid) begin
                held    = o_data;
                stalled = 1;
            end else begin
                stalled = 0;
            end
        end
        tick();
        i_ready = 1'b0;
        if (got < n) check($sformatf("%s_timeout", tag), got, n);
    endtask

    // ---------------- directed sequence ----------------
    int base;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        i_reset  = 1'b1;
        i_wr_ptr = '0;
        i_flush  = 1'b0;
        i_ready  = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_valid", o_valid, 0);
        check("rst_data",  o_data, 0);
        check("rst_rd_en", o_bram_rd_en, 0);
        check("rst_addr",  o_bram_rd_addr, 0);
        check("rst_rd_ptr", o_rd_ptr, 0);
        check("rst_used",  o_used, 0);
        check("rst_empty", o_empty, 1);
        i_reset = 1'b0;
        tick();

        // Single entry: valid three cycles after wr_ptr moves
        base = rd_cnt;
        write_entry(13'd0, 16'h253e);
        i_wr_ptr = 13'd1;
        tick();
        check("t1_issue_rd_en", o_bram_rd_en, 1);
        check("t1_issue_addr", o_bram_rd_addr, 0);
        check("t1_issue_valid", o_valid, 0);
        tick();
        check("t1_wait_valid", o_valid, 0);
        tick();
        check("t1_valid", o_valid, 1);
        check("t1_data", o_data, 16'h253e);
        check("t1_used", o_used, 1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("t1_rd_ptr", o_rd_ptr, 1);
        check("t1_empty", o_empty, 1);
        check("t1_valid_after", o_valid, 0);
        repeat (3) tick();
        check("t1_rd_count", rd_cnt - base, 1);

        // Back-to-back in the same line, no reset in between
        base = rd_cnt;
        write_entry(13'd1, 16'h22f7);
        write_entry(13'd2, 16'h25b7);
        write_entry(13'd3, 16'ha390);
        write_entry(13'd4, 16'ha40a);
        exp_q.push_back(16'h22f7);
        exp_q.push_back(16'h25b7);
        exp_q.push_back(16'ha390);
        exp_q.push_back(16'ha40a);
        i_wr_ptr = 13'd5;
        drain(4, 1'b0, "t2");
        repeat (3) tick();
        check("t2_rd_count", rd_cnt - base, 1);
        check("t2_rd_addr", addr_log[base[7:0]], 0);
        check("t2_valid_idle", o_valid, 0);
        check("t2_rd_ptr", o_rd_ptr, 5);

        // Line crossing: align to line 1 via flush, then 20 entries
        i_wr_ptr = 13'd16;
        i_flush  = 1'b1;
        tick();
        i_flush  = 1'b0;
        check("t3_flush_ptr", o_rd_ptr, 16);
        for (int i = 0; i < 20; i++) begin
            write_entry(13'(16 + i), 16'(i));
            exp_q.push_back(16'(i));
        end
        i_wr_ptr = 13'd36;
        drain(20, 1'b0, "t3");
        for (int i = 1; i < 20; i++) begin
            if (acc_cyc.size() == 20)
                check($sformatf("t3_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], (i == 16) ? 4 : 1);
        end
        check("t3_rd_ptr", o_rd_ptr, 36);

        // Backpressure over 64 entries
        for (int i = 0; i < 64; i++) begin
            write_entry(13'(36 + i), 16'hc000 + 16'(i * 37));
            exp_q.push_back(16'hc000 + 16'(i * 37));
        end
        i_wr_ptr = 13'd100;
        drain(64, 1'b1, "t4");
        repeat (3) tick();
        check("t4_rd_ptr", o_rd_ptr, 100);
        check("t4_empty", o_empty, 1);

        // Wrap from 8190 through 0
        i_wr_ptr = 13'd8190;
        i_flush  = 1'b1;
        tick();
        i_flush  = 1'b0;
        check("t5_flush_ptr", o_rd_ptr, 8190);
        base = rd_cnt;
        write_entry(13'd8190, 16'h5a01);
        write_entry(13'd8191, 16'h5a02);
        write_entry(13'd0,    16'h5a03);
        write_entry(13'd1,    16'h5a04);
        exp_q.push_back(16'h5a01);
        exp_q.push_back(16'h5a02);
        exp_q.push_back(16'h5a03);
        exp_q.push_back(16'h5a04);
        i_wr_ptr = 13'd2;
        drain(4, 1'b0, "t5");
        repeat (2) tick();
        check("t5_rd_count", rd_cnt - base, 2);
        check("t5_addr0", addr_log[base[7:0]], 511);
        check("t5_addr1", addr_log[8'(base + 1)], 0);
        check("t5_rd_ptr", o_rd_ptr, 2);
        for (int i = 0; i < 4; i++) begin
            if (acc_used.size() == 4)
                check($sformatf("t5_used%0d", i), acc_used[i], 4 - i);
        end
        check("t5_used_end", o_used, 0);

        // Flush mid-line with 10 pending; same-cycle accept is ignored
        for (int i = 0; i < 10; i++) write_entry(13'(2 + i), 16'h0f00 + 16'(i));
        i_wr_ptr = 13'd12;
        repeat (4) tick();
        check("t6_streaming", o_valid, 1);
        check("t6_data", o_data, 16'h0f00);
        i_flush = 1'b1;
        i_ready = 1'b1;
        tick();
        i_flush = 1'b0;
        i_ready = 1'b0;
        check("t6_valid_after_flush", o_valid, 0);
        check("t6_rd_ptr", o_rd_ptr, 12);
        check("t6_empty", o_empty, 1);
        tick();
        check("t6_still_idle", o_valid, 0);

        // Reset asserted during RD_WAIT
        write_entry(13'd12, 16'hbeef);
        i_wr_ptr = 13'd13;
        tick();
        tick();
        check("t7_in_wait", 32'(o_state), 32'(RD_WAIT));
        i_reset  = 1'b1;
        i_wr_ptr = '0;
        #1;
        check("t7_valid", o_valid, 0);
        check("t7_data", o_data, 0);
        check("t7_rd_en", o_bram_rd_en, 0);
        check("t7_addr", o_bram_rd_addr, 0);
        check("t7_rd_ptr", o_rd_ptr, 0);
        check("t7_used", o_used, 0);
        check("t7_empty", o_empty, 1);
        tick();
        i_reset = 1'b0;
        repeat (4) tick();
        check("t7_late_data_ignored", {o_valid, o_data}, 0);

        // Recovery after reset
        write_entry(13'd0, 16'h7e57);
        exp_q.push_back(16'h7e57);
        i_wr_ptr = 13'd1;
        drain(1, 1'b0, "t8");
        check("t8_rd_ptr", o_rd_ptr, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/result_bram_unpacker.md
# result_bram_unpacker

Downstream drain stage for the packed result BRAM. The result packer writes 16-bit results into 256-bit lines and publishes its entry write pointer. This block reads those lines back through the BRAM read port, unpacks them lane by lane and presents one result per cycle on a valid/ready stream. It owns the entry read pointer that the packer uses for occupancy and almost-full.

## Interface
- DATA_W, 16, result width in bits
- LINE_W, 256, BRAM line width; LANES = LINE_W/DATA_W = 16
- PTR_W, 13, entry pointer width; line address width ADDR_W = PTR_W - log2(LANES) = 9

Ports:
- i_clk  in  1  sole clock
- i_reset  in  1  asynchronous, active-high reset
- i_wr_ptr  in  PTR_W  packer entry write pointer; entries below it (mod 2^PTR_W) are committed
- i_flush  in  1  single-cycle pulse; discard all unread entries
- o_bram_rd_en  out  1  BRAM read enable
- o_bram_rd_addr  out  ADDR_W  BRAM line address
- i_bram_rd_data  in  LINE_W  read data, valid exactly 1 cycle after o_bram_rd_en
- o_valid  out  1  o_data holds an unread result
- o_data  out  DATA_W  current result
- i_ready  in  1  consumer accepts o_data when o_valid && i_ready
- o_rd_ptr  out  PTR_W  entry read pointer, fed back to the packer
- o_used  out  PTR_W+1  unread entries = {1'b0, (i_wr_ptr - o_rd_ptr) mod 2^PTR_W}
- o_empty  out  1  i_wr_ptr == o_rd_ptr

## Operation
- Pointer split: line = rd_ptr[PTR_W-1:4], lane = rd_ptr[3:0]. Lane k occupies line bits [16k+15:16k].
- States:
  - IDLE: transitions to RD_ISSUE when not empty.
  - RD_ISSUE: drives o_bram_rd_en=1 and o_bram_rd_addr=line. Snapshots limit <= i_wr_ptr. Next state is RD_WAIT.
  - RD_WAIT: captures i_bram_rd_data into the line register at the clock edge. Next state is STREAM.
  - STREAM: o_valid=1 and o_data = line_reg[lane]. On accept, rd_ptr <= rd_ptr+1. If the new lane is 0 or the new rd_ptr equals limit, the next state is IDLE; otherwise the block stays in STREAM.
- Limit snapshot semantics:
  - The packer advances wr_ptr only after its BRAM write commits, so every entry below the snapshot is in the read data.
  - Entries written into the same line after the snapshot are fetched by a re-read through IDLE. The block never emits stale lane data.
- Wrap-around: rd_ptr wraps from 8191 to 0 and the line address wraps from 511 to 0, with no special case.
- Full/empty convention:
  - Equal pointers always mean empty.
  - The packer holds occupancy at ≤ 2^PTR_W - 1 using its almost-full.
- i_flush (any state, any cycle):
  - rd_ptr <= i_wr_ptr and state <= IDLE.
  - An accept in the same cycle is ignored.
  - o_valid is low the following cycle.
- Reset: state IDLE, rd_ptr 0, limit 0, line register 0, o_valid 0, o_data 0, o_bram_rd_en 0, o_bram_rd_addr 0, o_used 0, o_empty 1.
- Reset may assert mid-read. Any late read data is ignored because the state is IDLE.
- o_data is stable while o_valid && !i_ready. o_valid never drops without an accept, except on flush or reset.

## Timing
- Empty to first valid: i_wr_ptr changes before edge N. Then RD_ISSUE is at N+1, RD_WAIT at N+2, and o_valid rises at N+3.
- Within a line, throughput is one result per cycle while i_ready=1.
- Line crossing: accept of lane 15 at cycle M gives IDLE at M+1, RD_ISSUE at M+2, RD_WAIT at M+3, and the next valid at M+4. This is 3 bubble cycles.
- Limit hit with i_wr_ptr already advanced: the re-read follows the same 3-cycle bubble.
- o_rd_ptr updates the cycle after an accept. o_used and o_empty are combinational from the registered rd_ptr and i_wr_ptr.

## Structure
- The shared package gemm_pkg holds:
  - RESULT_W=16, RESULT_LINE_W=256, RESULT_PTR_W=13, RESULT_LANES=16;
  - the typedef result_line_t;
  - the enum unpack_state_t {IDLE, RD_ISSUE, RD_WAIT, STREAM}.
- The block is a single module with no sub-module. The lane mux is a part-select inside it.

## Test plan
- Single entry:
  - Stimulus: after reset, write 0x253e at line 0 lane 0 and set wr_ptr=1.
  - Response: o_valid rises 3 cycles later with o_data=0x253e; after accept, o_rd_ptr=1, o_empty=1, and exactly one rd_en pulse.
- Back-to-back, no reset (duplicate-shift regression):
  - Stimulus: after the single-entry test, set wr_ptr=5 with lanes 1..4 = 0x22f7, 0x25b7, 0xa390, 0xa40a.
  - Response: the stream is exactly those four values in order, with no repeat of 0x253e and a single re-read of line 0.
- Line crossing:
  - Stimulus: fill 20 entries 0x0000..0x0013 and hold ready=1.
  - Response: 16 consecutive values, a 3-cycle gap, then 0x0010..0x0013.
- Backpressure:
  - Stimulus: toggle i_ready pseudo-randomly over 64 entries.
  - Response: o_data never changes while valid && !ready, and all 64 values arrive in order.
- Wrap:
  - Stimulus: start with rd_ptr=wr_ptr=8190 (via flush), then write 4 entries.
  - Response: read addresses are 511 then 0, o_rd_ptr ends at 2, and o_used shows 4,3,2,1,0.
- Flush and reset mid-line:
  - Stimulus: pulse i_flush during STREAM with 10 entries pending.
  - Response: o_valid is 0 on the next cycle and o_rd_ptr=i_wr_ptr.
  - Stimulus: assert i_reset during RD_WAIT.
  - Response: all outputs take their reset values immediately.
